// File: rtl/adder_op_issuer.sv
// Operand issuer for the 8-bit sample/done adder stage. Operand pairs are buffered in a
// small FIFO and issued one at a time. The sum is returned on a valid/ready port, and a
// timeout guards against a hung adder.
module adder_op_issuer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_a,
    input  logic [7:0]                 in_b,
    output logic                       sample,
    output logic [7:0]                 a,
    output logic [7:0]                 b,
    input  logic                       done,
    input  logic [8:0]                 c,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [8:0]                 res_sum,
    output logic                       err_timeout,
    input  logic                       err_clr,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FULL_C    = CW'(DEPTH);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            sample_q, sample_d;
    logic [7:0]      a_q, a_d;
    logic [7:0]      b_q, b_d;
    logic            res_valid_q, res_valid_d;
    logic [8:0]      res_sum_q, res_sum_d;
    logic            err_q, err_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [15:0]     mem_q [DEPTH];

    logic            push_s;
    logic            pop_s;
    logic            timeout_s;

    // Next-state, issue control and FIFO bookkeeping.
    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        a_d         = a_q;
        b_d         = b_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        cnt_d       = cnt_q;
        pop_s       = 1'b0;
        timeout_s   = 1'b0;
        push_s      = in_valid && (count_q != FULL_C);

        case (state_q)
            ST_IDLE: begin
                // done is deliberately not looked at here; it may be X from an unreset adder
                if ((count_q != {CW{1'b0}}) && !res_valid_q) begin
                    pop_s    = 1'b1;
                    a_d      = mem_q[rptr_q][15:8];
                    b_d      = mem_q[rptr_q][7:0];
                    sample_d = 1'b1;
                    state_d  = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                sample_d = 1'b0;
                cnt_d    = TW'(1);
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                // the first WAIT edge is when the adder raises done, so it is skipped
                if ((cnt_q >= TW'(2)) && done) begin
                    res_sum_d   = c;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else if (cnt_q == TIMEOUT_C) begin
                    timeout_s = 1'b1;
                    cnt_d     = {TW{1'b0}};
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                sample_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        if (timeout_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        wptr_d = push_s ? (wptr_q + PW'(1)) : wptr_q;
        rptr_d = pop_s  ? (rptr_q + PW'(1)) : rptr_q;

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wptr_q      <= {PW{1'b0}};
            rptr_q      <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            sample_q    <= 1'b0;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            res_valid_q <= 1'b0;
            res_sum_q   <= 9'h000;
            err_q       <= 1'b0;
            cnt_q       <= {TW{1'b0}};
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            sample_q    <= sample_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Operand storage; entries are only read after being written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= {in_a, in_b};
        end
    end

    assign in_ready    = (count_q != FULL_C);
    assign sample      = sample_q;
    assign a           = a_q;
    assign b           = b_q;
    assign res_valid   = res_valid_q;
    assign res_sum     = res_sum_q;
    assign err_timeout = err_q;
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_adder_op_issuer.sv
// Scoreboard bench for adder_op_issuer with a behavioural sample/done adder.
module tb_adder_op_issuer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a, in_b;
    logic       sample;
    logic [7:0] a, b;
    logic       done = 1'b0;
    logic [8:0] c = 9'h000;
    logic       res_valid;
    logic       res_ready;
    logic [8:0] res_sum;
    logic       err_timeout;
    logic       err_clr;
    logic [$clog2(DEPTH):0] fifo_count;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_op[$];
    logic [8:0]  exp_sum[$];

    bit          hang = 1'b0;
    logic        pend = 1'b0;
    logic [8:0]  pend_sum = 9'h000;

    adder_op_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .sample(sample), .a(a), .b(b),
        .done(done), .c(c), .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .err_timeout(err_timeout), .err_clr(err_clr),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Adder model: captures on a sampled pulse, done pulses one edge later.
    always @(posedge clk) begin
        if (pend) begin
            done <= !hang;
            c    <= pend_sum;
            pend <= 1'b0;
        end else begin
            done <= 1'b0;
        end
        if (sample) begin
            pend     <= 1'b1;
            pend_sum <= {1'b0, a} + {1'b0, b};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: operand issue, pulse width, latency and result scoreboard.
    int   cyc = 0, s_cyc = 0, slen = 0;
    logic prev_s = 1'b0, prev_v = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_s = 1'b0;
            prev_v = 1'b0;
            slen   = 0;
        end else begin
            if (sample && !prev_s) begin
                s_cyc = cyc;
                if (exp_op.size() == 0) chk("unexpected_issue", 32'd1, 32'd0);
                else chk("issue_ab", {16'h0, a, b}, {16'h0, exp_op.pop_front()});
            end
            if (sample) slen++;
            else if (prev_s) begin
                chk("sample_width", slen, 1);
                slen = 0;
            end
            if (res_valid && !prev_v) chk("latency", cyc - s_cyc, 3);
            if (res_valid && res_ready) begin
                if (exp_sum.size() == 0) chk("unexpected_result", {23'h0, res_sum}, 32'hFFFF);
                else chk("res_sum", {23'h0, res_sum}, {23'h0, exp_sum.pop_front()});
            end
            prev_s = sample;
            prev_v = res_valid;
        end
    end

    task automatic push(input logic [7:0] pa, input logic [7:0] pb, input logic [8:0] es, input bit drop);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = pa;
        in_b = pb;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk("push_stall", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            exp_op.push_back({pa, pb});
            if (!drop) exp_sum.push_back(es);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_sum.size() != 0 || fifo_count != 0 || res_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_bound", (n < 300), 1);
        repeat (2) @(negedge clk);
    endtask

    logic [7:0] bp_a [6] = '{8'h10, 8'h80, 8'h7F, 8'hC0, 8'h01, 8'hAA};
    logic [7:0] bp_b [6] = '{8'h20, 8'h90, 8'h01, 8'hC0, 8'hFE, 8'h55};
    logic [8:0] bp_s [6] = '{9'h030, 9'h110, 9'h080, 9'h180, 9'h0FF, 9'h0FF};

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
        res_ready = 1'b1; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sample", sample, 0);
        chk("rst_ab", {a, b}, 0);
        chk("rst_res", {res_valid, res_sum}, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_count", fifo_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        push(8'h12, 8'h34, 9'h046, 1'b0);
        wait_drain();
        push(8'hFF, 8'hFF, 9'h1FE, 1'b0);
        wait_drain();
        push(8'h00, 8'h00, 9'h000, 1'b0);
        wait_drain();

        push(8'h01, 8'h02, 9'h003, 1'b0);
        push(8'h03, 8'h04, 9'h007, 1'b0);
        chk("pushpop_count", fifo_count, 1);
        wait_drain();

        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(bp_a[i], bp_b[i], bp_s[i], 1'b0);
        repeat (3) @(negedge clk);
        chk("full_count", fifo_count, 4);
        chk("full_in_ready", in_ready, 0);
        chk("hold_valid", res_valid, 1);
        fork
            push(bp_a[5], bp_b[5], bp_s[5], 1'b0);
            begin
                repeat (4) @(negedge clk);
                chk("full_held", fifo_count, 4);
                res_ready = 1'b1;
            end
        join
        wait_drain();

        hang = 1'b1;
        push(8'h40, 8'h01, 9'h041, 1'b1);
        push(8'h02, 8'h03, 9'h005, 1'b0);
        @(negedge clk);
        n = 0;
        while (!sample && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!err_timeout && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_edges", n, TIMEOUT + 1);
        hang = 1'b0;
        wait_drain();
        chk("err_sticky", err_timeout, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_cleared", err_timeout, 0);

        push(8'h55, 8'h66, 9'h0BB, 1'b0);
        push(8'h11, 8'h22, 9'h033, 1'b0);
        @(negedge clk);
        n = 0;
        while (!sample && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_sample", sample, 0);
        chk("midrst_ab", {a, b}, 0);
        chk("midrst_valid", res_valid, 0);
        chk("midrst_count", fifo_count, 0);
        exp_op.delete();
        exp_sum.delete();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (res_valid) n++;
        end
        chk("late_done_ignored", n, 0);
        push(8'h80, 8'h80, 9'h100, 1'b0);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired act=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
